hazard_ctrl: RTL and testbench

- Sequencing and hazard controller for the 5-stage pipelined RV32 core.
- Generates the stall, flush and forwarding selects that drive the pipeline registers and the execute-stage forwarding muxes.
- Adds sequential control on top of the classic hazard equations:
  - a post-reset pipeline-clear state;
  - a data-memory wait state, where the whole pipeline freezes while the memory is not ready;
  - a memory-timeout halt;
  - saturating stall and flush performance counters.

---
 rtl/types_pkg.sv | 33 +++
 rtl/fwd_select.sv | 24 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the core's pipeline control: hazard FSM states,
// forwarding selects and the bundled stall/flush control word.
package types_pkg;

  typedef enum logic [1:0] {
    HZ_INIT     = 2'd0,
    HZ_RUN      = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_HALT     = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE   = hz_ctrl_t'(7'b0000000);
  localparam hz_ctrl_t CTRL_INIT   = hz_ctrl_t'(7'b1000110);
  // Whole pipeline held; the bubble goes into MEM/WB.
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(7'b1111001);

endpackage

// File: rtl/fwd_select.sv
// Execute-stage forwarding select for one source operand; M beats W.
module fwd_select
  import types_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rdM,
  input  logic [REG_ADDR_WIDTH-1:0] rdW,
  input  logic                      regWriteM,
  input  logic                      regWriteW,
  output fwd_sel_e                  fwdSel
);

  always_comb begin
    fwdSel = FWD_NONE;
    if (regWriteM && (rdM == rs) && (rs != '0)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW == rs) && (rs != '0)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: forwarding,
// load-use stalls, branch flushes, memory-wait freeze with timeout, perf counters.
//
// state       | meaning
// HZ_INIT     | one cycle after reset: hold PC, clear IF/ID and ID/EX
// HZ_RUN      | normal hazard handling
// HZ_MEM_WAIT | data memory busy, whole pipeline frozen
// HZ_HALT     | memory timed out, frozen until reset
module hazard_ctrl
  import types_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      MemAccessM,
  input  logic                      MemReadyM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      mem_fault,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [7:0]           WAIT_LOAD = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  hz_state_e  state, stateNext;
  logic [7:0] waitLeft, waitLeftNext;
  hz_ctrl_t   ctrl;
  fwd_sel_e   fwdA, fwdB;
  logic       lwStall, freeze, branchFlush;

  fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdA (
    .rs(Rs1E), .rdM(RdM), .rdW(RdW),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .fwdSel(fwdA)
  );

  fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdB (
    .rs(Rs2E), .rdM(RdM), .rdW(RdW),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .fwdSel(fwdB)
  );

  assign ForwardAE = fwdA;
  assign ForwardBE = fwdB;

  assign lwStall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign freeze  = MemAccessM && !MemReadyM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HZ_INIT;
      waitLeft <= '0;
    end else begin
      state    <= stateNext;
      waitLeft <= waitLeftNext;
    end
  end

  // waitLeft counts the frozen cycles still allowed; terminal count is 1.
  always_comb begin
    stateNext    = state;
    waitLeftNext = waitLeft;
    case (state)
      HZ_INIT: stateNext = HZ_RUN;
      HZ_RUN: begin
        if (freeze) begin
          if (WAIT_LOAD == 8'd0) begin
            stateNext = HZ_HALT;
          end else begin
            stateNext    = HZ_MEM_WAIT;
            waitLeftNext = WAIT_LOAD;
          end
        end
      end
      HZ_MEM_WAIT: begin
        if (!freeze) begin
          stateNext = HZ_RUN;
        end else if (waitLeft == 8'd1) begin
          stateNext = HZ_HALT;
        end else begin
          waitLeftNext = waitLeft - 8'd1;
        end
      end
      HZ_HALT: stateNext = HZ_HALT;
      default: stateNext = HZ_INIT;
    endcase
  end

  always_comb begin
    ctrl        = CTRL_IDLE;
    branchFlush = 1'b0;
    case (state)
      HZ_INIT: ctrl = CTRL_INIT;
      HZ_RUN, HZ_MEM_WAIT: begin
        if (freeze) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl.stallF = lwStall;
          ctrl.stallD = lwStall;
          ctrl.flushD = PCSrcE;
          ctrl.flushE = lwStall || PCSrcE;
          branchFlush = PCSrcE;
        end
      end
      HZ_HALT: ctrl = CTRL_FREEZE;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign StallF = ctrl.stallF;
  assign StallD = ctrl.stallD;
  assign StallE = ctrl.stallE;
  assign StallM = ctrl.stallM;
  assign FlushD = ctrl.flushD;
  assign FlushE = ctrl.flushE;
  assign FlushW = ctrl.flushW;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_fault <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mem_fault <= mem_fault || (stateNext == HZ_HALT);
      if (ctrl.stallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (branchFlush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and 4-bit counters.
// Control word order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_INIT   = 7'b1000110;
  localparam logic [6:0] C_FREEZE = 7'b1111001;
  localparam logic [6:0] C_LW     = 7'b1100010;
  localparam logic [6:0] C_BR     = 7'b0000110;
  localparam logic [6:0] C_LWBR   = 7'b1100110;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_fault;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemAccessM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // Ends one cycle after release, i.e. in RUN with stall_cnt == 1.
  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    nextCyc();
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ctrl !== C_INIT) begin errors++; $display("FAIL reset_init_ctrl got %b exp %b", ctrl, C_INIT); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    nextCyc();
    @(negedge clk);
    checks++; if (ctrl !== C_IDLE) begin errors++; $display("FAIL reset_run_ctrl got %b exp %b", ctrl, C_IDLE); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL reset_run_stall_cnt got %0d exp 1", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_mem_fault got %b exp 0", mem_fault); end
  endtask

  task automatic test_forward();
    nextCyc();
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwdA_m_prio got %b exp 10", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_x0 got %b exp 00", ForwardBE); end
    RegWriteM = 1'b0;
    #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_w got %b exp 01", ForwardAE); end
    RegWriteM = 1'b1; RdM = 5'd6; Rs2E = 5'd6;
    #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_w_rdm_miss got %b exp 01", ForwardAE); end
    checks++; if (ForwardBE !== 2'b10) begin errors++; $display("FAIL fwdB_m got %b exp 10", ForwardBE); end
    RegWriteW = 1'b0; Rs1E = 5'd9;
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdA_none got %b exp 00", ForwardAE); end
    clearInputs();
  endtask

  task automatic test_loaduse();
    doReset();
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    @(negedge clk);
    checks++; if (ctrl !== C_LW) begin errors++; $display("FAIL lw_rs2 got %b exp %b", ctrl, C_LW); end
    nextCyc();
    RdE = 5'd0; Rs2D = 5'd0;
    @(negedge clk);
    checks++; if (ctrl !== C_IDLE) begin errors++; $display("FAIL lw_rd0 got %b exp %b", ctrl, C_IDLE); end
    nextCyc();
    RdE = 5'd3; Rs1D = 5'd3;
    @(negedge clk);
    checks++; if (ctrl !== C_LW) begin errors++; $display("FAIL lw_rs1 got %b exp %b", ctrl, C_LW); end
    nextCyc();
    PCSrcE = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== C_LWBR) begin errors++; $display("FAIL lw_branch got %b exp %b", ctrl, C_LWBR); end
    nextCyc();
    ResultSrcE0 = 1'b0;
    @(negedge clk);
    checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL branch_only got %b exp %b", ctrl, C_BR); end
    nextCyc();
    clearInputs();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL lw_stall_cnt got %0d exp 4", stall_cnt); end
    checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL lw_flush_cnt got %0d exp 2", flush_cnt); end
  endtask

  task automatic test_concurrent();
    doReset();
    MemAccessM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL freeze_cyc%0d got %b exp %b", i, ctrl, C_FREEZE); end
      nextCyc();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL release_branch got %b exp %b", ctrl, C_BR); end
    nextCyc();
    clearInputs();
    @(negedge clk);
    checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL conc_flush_cnt got %0d exp 1", flush_cnt); end
    checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL conc_stall_cnt got %0d exp 4", stall_cnt); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL conc_no_fault got %b exp 0", mem_fault); end
    checks++; if (ctrl !== C_IDLE) begin errors++; $display("FAIL conc_after got %b exp %b", ctrl, C_IDLE); end
  endtask

  task automatic test_timeout();
    doReset();
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL to_freeze_cyc%0d got %b exp %b", i, ctrl, C_FREEZE); end
      checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL to_early_fault_cyc%0d got %b exp 0", i, mem_fault); end
      nextCyc();
    end
    @(negedge clk);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault_set got %b exp 1", mem_fault); end
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL to_stall_cnt got %0d exp 5", stall_cnt); end
    nextCyc();
    MemReadyM = 1'b1; PCSrcE = 1'b1; RdM = 5'd7; RegWriteM = 1'b1; Rs1E = 5'd7;
    @(negedge clk);
    checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL halt_hold got %b exp %b", ctrl, C_FREEZE); end
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL halt_fwd got %b exp 10", ForwardAE); end
    nextCyc();
    @(negedge clk);
    checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL halt_hold2 got %b exp %b", ctrl, C_FREEZE); end
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", mem_fault); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL halt_flush_cnt got %0d exp 0", flush_cnt); end
    reset = 1'b1;
    nextCyc();
    @(negedge clk);
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rst_fault_clr got %b exp 0", mem_fault); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_stall_clr got %0d exp 0", stall_cnt); end
    checks++; if (ctrl !== C_INIT) begin errors++; $display("FAIL rst_to_init got %b exp %b", ctrl, C_INIT); end
    reset = 1'b0;
    clearInputs();
    nextCyc();
  endtask

  task automatic test_saturate();
    doReset();
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    repeat (13) nextCyc();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d exp 14", stall_cnt); end
    repeat (4) nextCyc();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
    clearInputs();
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    test_reset();
    test_forward();
    test_loaduse();
    test_concurrent();
    test_timeout();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
